// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared receiver state encoding and frame helpers
package uart_rx_fifo_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
    localparam logic LINE_IDLE = 1'b1;
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: CPU-side read port and status flags of the receiver
interface uart_rx_fifo_if #(parameter int DATA_BITS = 8);
    logic                 rd_en;
    logic [DATA_BITS-1:0] rd_data;
    logic                 empty;
    logic                 full;
    logic                 frame_err;
    logic                 overflow;
    modport master (output rd_en, input rd_data, empty, full, frame_err, overflow);
    modport slave  (input rd_en, output rd_data, empty, full, frame_err, overflow);
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO; writes whenever wr_en, pops only when non-empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wptr, rptr;
    logic             pop;

    assign pop     = rd_en && !empty;
    assign empty   = wptr == rptr;
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

    // pointers wrap naturally; the extra MSB separates full from empty
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
        end
    end

    // storage needs no reset: rd_data is masked while empty
    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 mid-bit-sampling UART receiver feeding a FWFT byte FIFO
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 100000000,
    parameter int BAUD_RATE    = 115200,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_AW      = 3
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rx_in,
    uart_rx_fifo_if.slave  bus
);
    localparam int CPB = clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

    rx_state_t            state, state_n;
    logic                 rx_m, rx_s;
    logic [1:0]           warm;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 push, ferr_n, full, wr_en;

    // two-flop synchronizer; warm marks when rx_s reflects real line samples after reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_m <= LINE_IDLE;
            rx_s <= LINE_IDLE;
            warm <= '0;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
            warm <= {warm[0], 1'b1};
        end
    end

    // receiver state, baud counter, bit counter, shift register and frame error pulse
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= WAIT_HIGH;
            cnt           <= '0;
            bit_idx       <= '0;
            sh            <= '0;
            bus.frame_err <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bit_idx       <= bit_n;
            sh            <= sh_n;
            bus.frame_err <= ferr_n;
        end
    end

    // next-state: half-bit check of the start bit, then full-bit sampling of data and stop
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_idx;
        sh_n    = sh;
        push    = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: if (cnt == HALF) begin
                cnt_n   = '0;
                bit_n   = '0;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt == LAST) begin
                cnt_n = '0;
                sh_n  = {rx_s, sh[DATA_BITS-1:1]};
                bit_n = bit_idx + 1'b1;
                if (bit_idx == BW'(DATA_BITS - 1)) state_n = STOP;
            end
            STOP: if (cnt == LAST) begin
                cnt_n   = '0;
                push    = rx_s;
                ferr_n  = !rx_s;
                state_n = rx_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rx_s && warm[1]) state_n = IDLE;
            end
            default: state_n = WAIT_HIGH;
        endcase
    end

    // a push into a full FIFO survives only if the head is popped in the same cycle
    assign wr_en    = push && (!full || bus.rd_en);
    assign bus.full = full;

    // sticky drop flag, cleared only by reset
    always_ff @(posedge clk_in) begin
        if (rst_in) bus.overflow <= 1'b0;
        else if (push && full && !bus.rd_en) bus.overflow <= 1'b1;
    end

    sync_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .wr_en   (wr_en),
        .wr_data (sh_n),
        .rd_en   (bus.rd_en),
        .rd_data (bus.rd_data),
        .full    (full),
        .empty   (bus.empty)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames at 16 clocks per bit with hand-computed results
module tb_uart_rx_fifo;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rx_in  = 1'b1;
    int   total  = 0;
    int   bad    = 0;
    int   ferr_cnt = 0;

    uart_rx_fifo_if #(.DATA_BITS(8)) bus ();

    uart_rx_fifo #(.SYS_CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .FIFO_AW(3)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rx_in  (rx_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) if (bus.frame_err === 1'b1) ferr_cnt++;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       exp_byte;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic do_reset();
        @(negedge clk_in) rst_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in) rst_in = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk_in) bus.rd_en = 1'b1;
        @(negedge clk_in) bus.rd_en = 1'b0;
    endtask

    // drives one 160-cycle frame; negedge j drives the value seen at the j-th following posedge
    // stop sample is decided in cycle 153, so its effect is visible at negedge 155
    task automatic frame(input logic [7:0] d, input logic stop, input int rd_j, input int rst_j,
                         output logic e_pre, output logic e_post, output logic [7:0] d_post,
                         output logic fe_post);
        for (int j = 0; j < 160; j++) begin
            @(negedge clk_in);
            if (j == 154) e_pre = bus.empty;
            if (j == 155) begin
                e_post  = bus.empty;
                d_post  = bus.rd_data;
                fe_post = bus.frame_err;
            end
            rx_in     = (j < 16) ? 1'b0 : (j < 144) ? d[(j - 16) / 16] : stop;
            bus.rd_en = (j == rd_j);
            rst_in    = (j == rst_j);
        end
        @(negedge clk_in);
        bus.rd_en = 1'b0;
        rst_in    = 1'b0;
    endtask

    logic       e_pre, e_post, fe_post;
    logic [7:0] d_post;
    int         f0;

    initial begin
        bus.rd_en = 1'b0;
        vecs[0] = '{8'hA5, 1'b1, 1'b1};
        vecs[1] = '{8'h3C, 1'b1, 1'b1};
        vecs[2] = '{8'h81, 1'b1, 1'b1};
        vecs[3] = '{8'h55, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b1};
        vecs[5] = '{8'h7E, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 1'b1, 1'b1};

        do_reset();
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_data", bus.rd_data, 0);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_ovf", bus.overflow, 0);
        idle(10);

        for (int i = 0; i < 8; i++) begin
            f0 = ferr_cnt;
            frame(vecs[i].d, vecs[i].stop, -1, -1, e_pre, e_post, d_post, fe_post);
            rx_in = 1'b1;
            idle(20);
            check("tbl_empty_pre", e_pre, 1);
            check("tbl_empty_post", e_post, !vecs[i].exp_byte);
            check("tbl_ferr_pulse", fe_post, !vecs[i].stop);
            check("tbl_ferr_count", ferr_cnt - f0, vecs[i].stop ? 0 : 1);
            if (vecs[i].exp_byte) begin
                check("tbl_data_post", d_post, vecs[i].d);
                check("tbl_data", bus.rd_data, vecs[i].d);
                pop();
            end
            check("tbl_empty_end", bus.empty, 1);
        end
        pop();
        check("pop_when_empty", bus.empty, 1);

        // line held low from reset
        rx_in = 1'b0;
        do_reset();
        f0 = ferr_cnt;
        idle(500);
        check("stuck_empty", bus.empty, 1);
        check("stuck_ferr", ferr_cnt - f0, 0);
        rx_in = 1'b1;
        idle(10);
        frame(8'h3C, 1'b1, -1, -1, e_pre, e_post, d_post, fe_post);
        idle(5);
        check("stuck_after", bus.rd_data, 8'h3C);
        pop();

        // short glitch on idle line
        f0 = ferr_cnt;
        @(negedge clk_in) rx_in = 1'b0;
        idle(3);
        @(negedge clk_in) rx_in = 1'b1;
        idle(40);
        check("glitch_empty", bus.empty, 1);
        check("glitch_ferr", ferr_cnt - f0, 0);
        frame(8'h81, 1'b1, -1, -1, e_pre, e_post, d_post, fe_post);
        idle(5);
        check("glitch_after", bus.rd_data, 8'h81);
        pop();

        // bad stop followed by line held low
        f0 = ferr_cnt;
        frame(8'h55, 1'b0, -1, -1, e_pre, e_post, d_post, fe_post);
        idle(40);
        check("brk_ferr", ferr_cnt - f0, 1);
        check("brk_empty", bus.empty, 1);
        rx_in = 1'b1;
        idle(10);
        frame(8'h01, 1'b1, -1, -1, e_pre, e_post, d_post, fe_post);
        idle(5);
        check("brk_after", bus.rd_data, 8'h01);
        check("brk_ferr_total", ferr_cnt - f0, 1);
        pop();

        // fill to full, then overflow
        do_reset();
        idle(5);
        for (int i = 0; i < 8; i++) begin
            frame(8'(i), 1'b1, -1, -1, e_pre, e_post, d_post, fe_post);
            idle(4);
            check("fill_full", bus.full, i == 7);
        end
        check("fill_ovf_pre", bus.overflow, 0);
        frame(8'h08, 1'b1, -1, -1, e_pre, e_post, d_post, fe_post);
        idle(4);
        check("ovf_set", bus.overflow, 1);
        check("ovf_full", bus.full, 1);
        for (int i = 0; i < 8; i++) begin
            check("ovf_read", bus.rd_data, i);
            pop();
        end
        check("ovf_drain_empty", bus.empty, 1);
        check("ovf_sticky", bus.overflow, 1);

        // push while full with simultaneous pop
        do_reset();
        idle(5);
        for (int i = 0; i < 8; i++) begin
            frame(8'(i), 1'b1, -1, -1, e_pre, e_post, d_post, fe_post);
            idle(4);
        end
        frame(8'h08, 1'b1, 154, -1, e_pre, e_post, d_post, fe_post);
        idle(4);
        check("pp_ovf", bus.overflow, 0);
        check("pp_full", bus.full, 1);
        for (int i = 1; i < 9; i++) begin
            check("pp_read", bus.rd_data, i);
            pop();
        end
        check("pp_empty", bus.empty, 1);

        // reset in the middle of data bit 3
        f0 = ferr_cnt;
        frame(8'hFF, 1'b1, -1, 70, e_pre, e_post, d_post, fe_post);
        idle(20);
        check("mid_rst_empty", bus.empty, 1);
        check("mid_rst_ferr", ferr_cnt - f0, 0);
        frame(8'h7E, 1'b1, -1, -1, e_pre, e_post, d_post, fe_post);
        idle(5);
        check("mid_rst_after", bus.rd_data, 8'h7E);
        check("mid_rst_nonempty", bus.empty, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
